// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-wide data memory.
// Sub-word stores are read-modify-write; lanes are big-endian.
module mem_access_unit #(
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;

    logic [31:0] wix;
    logic        bad_align;
    logic        bad_range;
    logic        req_err;
    logic [7:0]  byte_l;
    logic [15:0] half_l;
    logic [31:0] load_v;
    logic [31:0] merged;

    assign wix = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};

    assign bad_align = (req_size == 2'b11)
                     | ((req_size == 2'b01) & req_addr[0])
                     | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    // second term only matters for a non-power-of-two depth
    assign bad_range = (req_addr[31:IDX_W+2] != '0)
                     | (wix >= 32'(MEM_WORDS));
    assign req_err   = bad_align | bad_range;

    always_comb begin
        byte_l = Read_data[7:0];
        unique case (off_q)
            2'd0: byte_l = Read_data[31:24];
            2'd1: byte_l = Read_data[23:16];
            2'd2: byte_l = Read_data[15:8];
            2'd3: byte_l = Read_data[7:0];
        endcase
        half_l = off_q[1] ? Read_data[15:0] : Read_data[31:16];
        unique case (size_q)
            2'b00:   load_v = {{24{sgn_q & byte_l[7]}}, byte_l};
            2'b01:   load_v = {{16{sgn_q & half_l[15]}}, half_l};
            default: load_v = Read_data;
        endcase
    end

    always_comb begin
        merged = Read_data;
        if (size_q == 2'b00) begin
            unique case (off_q)
                2'd0: merged[31:24] = wdata_q[7:0];
                2'd1: merged[23:16] = wdata_q[7:0];
                2'd2: merged[15:8]  = wdata_q[7:0];
                2'd3: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[15:0] = wdata_q;
        end else begin
            merged[31:16] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        err_q   <= req_err;
                        rdata_q <= '0;
                        if (req_err) begin
                            state <= RESP;
                        end else begin
                            addr_q <= wix;
                            if (req_write && req_size == 2'b10) begin
                                wd_q  <= req_wdata;
                                state <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (wr_q) begin
                        wd_q  <= merged;
                        state <= WR;
                    end else begin
                        rdata_q <= load_v;
                        state   <= RESP;
                    end
                end
                WR:   state <= RESP;
                RESP: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign MemRead    = (state == RD);
    assign MemWrite   = (state == WR);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) & err_q;
    assign resp_rdata = (state == RESP) ? rdata_q : '0;
    assign Address    = addr_q;
    assign Write_data = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset abort, back-to-back
// and random traffic against a byte-level reference memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    logic [31:0] mem     [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(256), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data),
        .Read_data(Read_data)
    );

    assign Read_data = mem[Address[7:0]];

    always @(posedge clk) begin
        if (MemWrite) mem[Address[7:0]] <= Write_data;
    end

    task automatic chk(input logic ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_b(input logic [31:0] w, input int p);
        return 8'((w >> (8 * (3 - p))) & 32'hFF);
    endfunction

    // Reference: byte-addressed memory, big-endian within a word
    function automatic void model(input logic w, input logic [1:0] sz,
                                  input logic sg, input logic [31:0] a,
                                  input logic [31:0] wd,
                                  output logic e_err, output logic [31:0] e_rd,
                                  output int e_lat, output logic [31:0] e_wd);
        int n;
        int idx;
        int off;
        logic [31:0] word;
        longint val;
        e_rd = 0;
        e_wd = 0;
        n = 1 << sz;
        e_err = (sz == 3) || (sz == 1 && a % 2 != 0)
             || (sz == 2 && a % 4 != 0) || (a >= 32'd1024);
        if (e_err) begin
            e_lat = 1;
            return;
        end
        idx = int'(a / 4);
        off = int'(a % 4);
        word = ref_mem[idx];
        if (!w) begin
            val = 0;
            for (int k = 0; k < n; k++) val = val * 256 + longint'(get_b(word, off + k));
            if (sg && n < 4 && val >= (longint'(1) << (8 * n - 1)))
                val = val - (longint'(1) << (8 * n));
            e_rd = 32'(val);
            e_lat = 2;
        end else begin
            for (int k = 0; k < n; k++) begin
                int p;
                logic [31:0] b;
                p = 8 * (3 - (off + k));
                b = (wd >> (8 * (n - 1 - k))) & 32'hFF;
                word = (word & ~(32'hFF << p)) | (b << p);
            end
            ref_mem[idx] = word;
            e_wd = word;
            e_lat = (n == 4) ? 2 : 3;
        end
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd,
                          input int e_lat, input logic [31:0] e_wd,
                          input string name);
        int g = 0;
        int lat = 0;
        logic saw_rd = 0, saw_wr = 0, both = 0, addr_bad = 0, leak = 0;
        logic got_err = 0;
        logic [31:0] got_rd = 0, wd_seen = 0;
        @(negedge clk);
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk(req_ready, {name, " ready"}, 32'(req_ready), 1);
        req_valid = 1; req_write = w; req_size = sz;
        req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (MemRead && MemWrite) both = 1;
            if (MemRead) saw_rd = 1;
            if (MemWrite) begin
                saw_wr = 1;
                wd_seen = Write_data;
            end
            if ((MemRead || MemWrite) && Address != {22'h0, a[9:2]}) addr_bad = 1;
            if (!resp_valid && resp_rdata != 0) leak = 1;
            if (resp_valid) begin
                lat = n;
                got_err = resp_err;
                got_rd = resp_rdata;
                break;
            end
        end
        chk(lat == e_lat, {name, " latency"}, 32'(lat), 32'(e_lat));
        chk(got_err == e_err, {name, " err"}, 32'(got_err), 32'(e_err));
        chk(got_rd == e_rd, {name, " rdata"}, got_rd, e_rd);
        chk(saw_wr == (w && !e_err), {name, " MemWrite"}, 32'(saw_wr), 32'(w && !e_err));
        chk(saw_rd == (!e_err && !(w && sz == 2)), {name, " MemRead"},
            32'(saw_rd), 32'(!e_err && !(w && sz == 2)));
        chk(!both && !addr_bad && !leak, {name, " strobes/addr"},
            {29'h0, both, addr_bad, leak}, 0);
        if (w && !e_err) chk(wd_seen == e_wd, {name, " Write_data"}, wd_seen, e_wd);
    endtask

    task automatic run_model(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input string name);
        logic e_err;
        logic [31:0] e_rd, e_wd;
        int e_lat;
        model(w, sz, sg, a, wd, e_err, e_rd, e_lat, e_wd);
        do_req(w, sz, sg, a, wd, e_err, e_rd, e_lat, e_wd, name);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic e_err;
        logic [31:0] e_rd, e_wd;
        int e_lat;
        int bad;

        vt.push_back('{1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        2});
        vt.push_back('{0, 2'd2, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 2});
        vt.push_back('{1, 2'd0, 0, 32'h11,  32'h5A,       0, 32'h0,        3});
        vt.push_back('{0, 2'd2, 0, 32'h10,  32'h0,        0, 32'hDE5ABEEF, 2});
        vt.push_back('{0, 2'd0, 1, 32'h11,  32'h0,        0, 32'h0000005A, 2});
        vt.push_back('{0, 2'd1, 1, 32'h12,  32'h0,        0, 32'hFFFFBEEF, 2});
        vt.push_back('{0, 2'd1, 0, 32'h12,  32'h0,        0, 32'h0000BEEF, 2});
        vt.push_back('{0, 2'd2, 0, 32'h13,  32'h0,        1, 32'h0,        1});
        vt.push_back('{0, 2'd1, 0, 32'h11,  32'h0,        1, 32'h0,        1});
        vt.push_back('{0, 2'd3, 0, 32'h10,  32'h0,        1, 32'h0,        1});
        vt.push_back('{0, 2'd2, 0, 32'h400, 32'h0,        1, 32'h0,        1});
        vt.push_back('{1, 2'd1, 0, 32'h12,  32'hFFFF1234, 0, 32'h0,        3});
        vt.push_back('{0, 2'd0, 0, 32'h10,  32'h0,        0, 32'h000000DE, 2});
        vt.push_back('{0, 2'd0, 1, 32'h10,  32'h0,        0, 32'hFFFFFFDE, 2});
        vt.push_back('{0, 2'd2, 0, 32'h10,  32'h0,        0, 32'hDE5A1234, 2});
        vt.push_back('{1, 2'd0, 0, 32'h3FF, 32'h77,       0, 32'h0,        3});
        vt.push_back('{0, 2'd2, 0, 32'h3FC, 32'h0,        0, 32'h00000077, 2});
        vt.push_back('{1, 2'd2, 0, 32'h414, 32'h1,        1, 32'h0,        1});

        rst_n = 0; req_valid = 0; req_write = 0; req_size = 0;
        req_signed = 0; req_addr = 0; req_wdata = 0;
        #12;
        chk(req_ready == 1, "reset req_ready", 32'(req_ready), 1);
        chk({MemRead, MemWrite, resp_valid, resp_err} == 0, "reset strobes",
            {28'h0, MemRead, MemWrite, resp_valid, resp_err}, 0);
        chk(resp_rdata == 0 && Address == 0 && Write_data == 0, "reset data",
            resp_rdata | Address | Write_data, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vt[i]) begin
            model(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd,
                  e_err, e_rd, e_lat, e_wd);
            do_req(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd,
                   vt[i].e_err, vt[i].e_rd, vt[i].e_lat, e_wd,
                   $sformatf("vec%0d", i));
        end

        // reset in the middle of a sub-word store's read phase
        run_model(1, 2'd2, 0, 32'h20, 32'h11223344, "pre-abort sw");
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 0;
        req_addr = 32'h21; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        chk(MemRead == 1, "abort in RD", 32'(MemRead), 1);
        #1 rst_n = 0;
        #1;
        chk(!MemRead && !MemWrite && req_ready && !resp_valid, "async reset",
            {28'h0, MemRead, MemWrite, req_ready, resp_valid}, 32'b0010);
        @(negedge clk);
        rst_n = 1;
        run_model(0, 2'd2, 0, 32'h20, 0, "post-abort lw");

        // back-to-back with req_valid held high
        begin
            logic         bw[3] = '{1, 0, 0};
            logic [1:0]   bs[3] = '{2'd2, 2'd2, 2'd0};
            logic [31:0]  ba[3] = '{32'h40, 32'h40, 32'h43};
            logic [31:0]  exp_q[$];
            int acc = 0, nresp = 0;
            logic take;
            for (int i = 0; i < 3; i++) begin
                model(bw[i], bs[i], 0, ba[i], 32'hCAFEF00D, e_err, e_rd, e_lat, e_wd);
                exp_q.push_back(e_rd);
            end
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (resp_valid) begin
                    if (exp_q.size() > 0) begin
                        e_rd = exp_q.pop_front();
                        chk(resp_rdata == e_rd && !resp_err,
                            $sformatf("b2b resp%0d", nresp), resp_rdata, e_rd);
                    end
                    nresp++;
                end
                take = 0;
                if (acc < 3) begin
                    req_valid = 1; req_write = bw[acc]; req_size = bs[acc];
                    req_signed = 0; req_addr = ba[acc]; req_wdata = 32'hCAFEF00D;
                    take = req_ready;
                end else begin
                    req_valid = 0;
                end
                @(posedge clk);
                if (take) acc++;
            end
            chk(acc == 3, "b2b accepts", 32'(acc), 3);
            chk(nresp == 3, "b2b responses", 32'(nresp), 3);
        end

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 1023));
            run_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, $urandom,
                      $sformatf("rnd%0d", i));
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != ref_mem[i]) bad++;
        chk(bad == 0, "memory image", 32'(bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
